// File: rtl/bitset_unroller.sv
// bitset_unroller: captures a word and replays it as one valid/ready beat per set bit,
// each beat carrying the bit index, its one-hot mask and a last flag.
module bitset_unroller #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int IW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IW-1:0]    out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero_drop,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] pending;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] sel_onehot;
    logic             sel_last;
    logic             accept;
    logic             transfer;

    // Priority pick over pending; the later loop assignment wins, so the scan
    // direction decides whether the lowest or the highest set bit is chosen.
    always_comb begin
        sel_idx = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    sel_idx = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) begin
                    sel_idx = IW'(i);
                end
            end
        end
    end

    assign sel_onehot = WIDTH'(1) << sel_idx;
    assign sel_last   = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    assign accept   = (state == IDLE) && in_valid;
    assign transfer = (state == SCAN) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && (in != '0)) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (transfer && sel_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A zero word is accepted but leaves pending empty, so IDLE is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            zero_drop <= 1'b0;
        end else begin
            zero_drop <= accept && (in == '0);
            if (accept) begin
                pending <= in;
            end else if (transfer) begin
                pending <= pending & ~sel_onehot;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, even mid-scan.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_idx    = '0;
        out_onehot = '0;
        out_last   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                end
                SCAN: begin
                    out_valid  = 1'b1;
                    busy       = 1'b1;
                    out_idx    = sel_idx;
                    out_onehot = sel_onehot;
                    out_last   = sel_last;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bitset_unroller.md
Name: bitset_unroller

Overview:
- Inverse counterpart of the 8-way OR reduction: instead of collapsing an 8-bit word to a single "any bit set" flag, it expands a captured word into one output beat per set bit.
- Each beat carries the bit index, its one-hot mask and a last flag.
- Both sides use valid/ready handshakes.
- Sits between request-aggregation logic and per-channel consumers, for example interrupt or request dispatch in the Hack platform glue.

Parameters:
- WIDTH, 8, input word width; must be at least 2. IW = clog2(WIDTH), so IW = 3 at the default.
- LSB_FIRST, 1, 1 emits lowest set bit first; 0 emits highest set bit first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  word to unroll.
- in_valid  input  1  in is valid.
- in_ready  output  1  block can accept a word.
- out_idx  output  IW  index of the current set bit.
- out_onehot  output  WIDTH  one-hot mask of the current bit (1 << out_idx).
- out_last  output  1  current beat is the final set bit of the word.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts the beat.
- zero_drop  output  1  one-cycle pulse: an all-zero word was accepted and discarded.
- busy  output  1  high while the block is in SCAN.

Behaviour:
- State
  - Registers: state (IDLE, SCAN) and pending[WIDTH-1:0].
  - Reset: state=IDLE, pending=0, zero_drop=0.
  - Outputs during reset: in_ready=0, out_valid=0, out_idx=0, out_onehot=0, out_last=0, busy=0.
- IDLE
  - in_ready=1 and out_valid=0.
  - An input fires on the edge where in_valid && in_ready.
  - Nonzero in: pending<=in, state<=SCAN.
  - in==0: stay in IDLE, zero_drop<=1 for exactly the next cycle, no output beat.
- SCAN
  - in_ready=0; in and in_valid are ignored, with no overlap between words.
  - busy=1 and out_valid=1.
- Beat selection (combinational from pending)
  - out_idx is the lowest set bit of pending when LSB_FIRST=1, otherwise the highest set bit.
  - out_onehot = 1 << out_idx.
  - out_last = 1 when exactly one bit of pending is set.
- Beat transfer
  - Fires on the edge where out_valid && out_ready.
  - pending <= pending & ~out_onehot.
  - If out_last was 1: state<=IDLE.
- Stall: with out_ready=0, all outputs hold stable and pending is unchanged, for any number of cycles.
- Latency
  - Word accepted at edge N: first beat has out_valid=1 in cycle N+1.
  - Each subsequent beat follows one cycle after the previous transfer, given out_ready=1.
  - A word with k set bits takes k transfer cycles.
  - in_ready returns high in the cycle after the last transfer.
- Throughput: with out_ready held at 1, the steady-state cost is k+1 cycles per word (one accept cycle plus k beats).
- Width rules
  - out_idx is IW bits.
  - WIDTH need not be a power of 2; out_idx never exceeds WIDTH-1.
- Reset mid-operation
  - reset=1 in SCAN abandons pending bits; no further beats are emitted.
  - Next cycle state=IDLE, out_valid=0, and in_ready=1 once reset deasserts.
  - reset overrides a simultaneous accept or transfer.
- Invariant: out_valid=1 implies pending!=0, out_onehot has exactly one bit set, and that bit is set in pending.
- zero_drop is registered and is never high in the same cycle as out_valid, because the block remains in IDLE.

Test Plan:
1. Reset, then in=8'b1010_0100 with in_valid=1 for one cycle and out_ready=1 (LSB_FIRST=1) -> beats idx 2, 5, 7 on consecutive cycles; out_last=1 only on idx 7; in_ready returns high the cycle after idx 7.
2. Same word with LSB_FIRST=0 -> beats idx 7, 5, 2, with onehot 0x80, 0x20, 0x04.
3. in=8'hFF with out_ready toggling 1,0,0,1,... -> eight beats idx 0..7 in order; out_idx, out_onehot and out_last hold stable during stalls; no beat is duplicated or lost.
4. in=8'h00 accepted -> no out_valid; zero_drop high for exactly one cycle; in_ready stays 1; next word in=8'h01 produces a single beat idx 0 with out_last=1.
5. in=8'h81 accepted, reset asserted after the first beat -> next cycle out_valid=0 and busy=0; after release in_ready=1 and beat idx 7 is never emitted.
6. in_valid held high with a new word while in SCAN -> in_ready=0 and the word is not consumed until IDLE; bench scoreboard confirms the beat count equals popcount per word over 1000 random words with random out_ready.
